// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-word adder that reuses one carry-bypass slice, least significant word first.
module carry_bypass_adder #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = (WIDTH + BLOCK - 1) / BLOCK;
    logic blockCarry, rippleCarry, allProp, p;
    // Each block ripples internally; the block carry skips past it when every bit propagates.
    always_comb begin
        sum = '0;
        blockCarry = cin;
        rippleCarry = 1'b0;
        allProp = 1'b0;
        p = 1'b0;
        for (int k = 0; k < NB; k++) begin
            rippleCarry = blockCarry;
            allProp = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                if (k * BLOCK + i < WIDTH) begin
                    p = opA[k*BLOCK+i] ^ opB[k*BLOCK+i];
                    sum[k*BLOCK+i] = p ^ rippleCarry;
                    rippleCarry = (opA[k*BLOCK+i] & opB[k*BLOCK+i]) | (p & rippleCarry);
                    allProp = allProp & p;
                end
            end
            blockCarry = allProp ? blockCarry : rippleCarry;
        end
        cout = blockCarry;
    end
endmodule

module wide_add_sequencer #(
    parameter int ADDER_WIDTH = 8,
    parameter int NUM_WORDS = 4
) (
    input  logic                             iClk,
    input  logic                             iRst,
    input  logic                             iStart,
    input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iA,
    input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iB,
    input  logic                             iCarry,
    output logic [ADDER_WIDTH*NUM_WORDS-1:0] oSum,
    output logic                             oCarry,
    output logic                             oBusy,
    output logic                             oDone
);
    localparam int W = ADDER_WIDTH * NUM_WORDS;
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, nextState;
    logic [W-1:0] aReg, bReg;
    logic [IW-1:0] idx;
    logic carryReg, lastWord, wordCarry;
    logic [ADDER_WIDTH-1:0] wordSum;
    assign lastWord = idx == IW'(NUM_WORDS - 1);
    carry_bypass_adder #(.WIDTH(ADDER_WIDTH)) slice (
        .opA (aReg[idx*ADDER_WIDTH +: ADDER_WIDTH]),
        .opB (bReg[idx*ADDER_WIDTH +: ADDER_WIDTH]),
        .cin (carryReg),
        .sum (wordSum),
        .cout(wordCarry)
    );
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = iStart ? ADD : IDLE;
            ADD: nextState = lastWord ? DONE : ADD;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            aReg <= '0;
            bReg <= '0;
            idx <= '0;
            carryReg <= 1'b0;
            oSum <= '0;
            oCarry <= 1'b0;
        end else if (state == IDLE && iStart) begin
            aReg <= iA;
            bReg <= iB;
            carryReg <= iCarry;
            idx <= '0;
        end else if (state == ADD) begin
            oSum[idx*ADDER_WIDTH +: ADDER_WIDTH] <= wordSum;
            carryReg <= wordCarry;
            idx <= lastWord ? '0 : idx + IW'(1);
            if (lastWord) oCarry <= wordCarry;
        end
    end
    assign oBusy = state == ADD;
    assign oDone = state == DONE;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed and random additions checked against plain integer arithmetic.
module tb_wide_add_sequencer;
    logic iClk = 1'b0, iRst = 1'b1, iStart = 1'b0, iCarry = 1'b0;
    logic [31:0] iA = '0, iB = '0, oSum;
    logic oCarry, oBusy, oDone;
    int checks = 0, errors = 0;

    wide_add_sequencer #(.ADDER_WIDTH(8), .NUM_WORDS(4)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iA(iA), .iB(iB), .iCarry(iCarry),
        .oSum(oSum), .oCarry(oCarry), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input bit restartInDone);
        logic [32:0] exp;
        int edges, busyCnt;
        exp = {1'b0, a} + {1'b0, b} + 33'(c);
        iA = a; iB = b; iCarry = c; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iA = $urandom; iB = $urandom; iCarry = 1'($urandom);
        edges = 1; busyCnt = 0;
        while (!oDone && edges < 20) begin
            if (oBusy) busyCnt++;
            tick();
            iA = $urandom; iB = $urandom;
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'd5);
        check({tag, " busy cycles"}, 64'(busyCnt), 64'd4);
        check({tag, " busy with done"}, 64'(oBusy), 64'd0);
        check({tag, " sum"}, 64'(oSum), 64'(exp[31:0]));
        check({tag, " carry"}, 64'(oCarry), 64'(exp[32]));
        if (restartInDone) iStart = 1'b1;
        tick();
        check({tag, " done single"}, 64'(oDone), 64'd0);
        check({tag, " start ignored"}, 64'(oBusy), 64'd0);
        check({tag, " sum held"}, 64'({oCarry, oSum}), 64'(exp));
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] ra, rb;
        logic rc;
        iStart = 1'b1;
        tick();
        tick();
        check("reset sum", 64'(oSum), 64'd0);
        check("reset carry", 64'(oCarry), 64'd0);
        check("reset busy over start", 64'(oBusy), 64'd0);
        check("reset done", 64'(oDone), 64'd0);
        iRst = 1'b0; iStart = 1'b0;
        tick();
        check("idle without start", 64'(oBusy), 64'd0);
        runOp("ff+1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        runOp("ripple all", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        runOp("all ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            runOp("random", ra, rb, rc, 1'b0);
        end
        // Held start: acceptance only on IDLE edges, one every six cycles.
        exp = '0;
        iStart = 1'b1;
        for (int n = 0; n < 24; n++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            iA = ra; iB = rb; iCarry = rc;
            if (n % 6 == 0) exp = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            tick();
            check("held start done", 64'(oDone), 64'(n % 6 == 4));
            if (n % 6 == 4) check("held start result", 64'({oCarry, oSum}), 64'(exp));
        end
        iStart = 1'b0;
        tick();
        check("held start idle", 64'(oBusy), 64'd0);
        iA = 32'hAAAAAAAA; iB = 32'h55555555; iCarry = 1'b1; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        check("second add busy", 64'(oBusy), 64'd1);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("abort busy", 64'(oBusy), 64'd0);
        check("abort done", 64'(oDone), 64'd0);
        check("abort sum", 64'({oCarry, oSum}), 64'd0);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("abort no done", 64'({oBusy, oDone}), 64'd0);
        end
        runOp("after abort", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
        check("after abort value", 64'({oCarry, oSum}), 64'h023456789);
        runOp("start in done", 32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 1'b1);
        runOp("restart", 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
